// File: rtl/fire_pkg.sv
// Shared constants, phase-to-channel table and FSM state type for the
// fire pulse scheduler.
package fire_pkg;

  localparam int NCH   = 6;
  localparam int NPH   = 6;
  localparam int CNT_W = 24;

  localparam int SLOT_CYC_DEF   = 165000;
  localparam int PULSE_CYC_DEF  = 25000;
  localparam int FB_WIN_CYC_DEF = 50000;

  localparam logic [2:0] CH_ABP = 3'd0;
  localparam logic [2:0] CH_ABN = 3'd1;
  localparam logic [2:0] CH_BCP = 3'd2;
  localparam logic [2:0] CH_BCN = 3'd3;
  localparam logic [2:0] CH_CAP = 3'd4;
  localparam logic [2:0] CH_CAN = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GAP   = 2'd1,
    ST_PULSE = 2'd2
  } fire_state_e;

  // Firing order: BC-, AB+, CA-, BC+, AB-, CA+
  function automatic logic [2:0] phase_ch(
    input logic [2:0] ph
  );
    case (ph)
      3'd0:    phase_ch = CH_BCN;
      3'd1:    phase_ch = CH_ABP;
      3'd2:    phase_ch = CH_CAN;
      3'd3:    phase_ch = CH_BCP;
      3'd4:    phase_ch = CH_ABN;
      3'd5:    phase_ch = CH_CAP;
      default: phase_ch = CH_BCN;
    endcase
  endfunction

  function automatic logic [NCH-1:0] phase_sel(
    input logic [2:0] ph
  );
    phase_sel = NCH'(1) << phase_ch(ph);
  endfunction

endpackage

// File: rtl/fire_fb_window.sv
// One-channel feedback checker: rising-edge detect, acceptance window
// opened by start, sticky loss flag cleared by clr (a new loss wins).
module fire_fb_window
  import fire_pkg::*;
#(
  parameter int WIN_CYC = FB_WIN_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic fb,
  input  logic clr,
  output logic lost,
  output logic loss_set
);

  logic             fb_q;
  logic             open;
  logic             seen;
  logic [CNT_W-1:0] wcnt;
  logic             rise;
  logic             last;
  logic             hit;

  assign rise = fb & ~fb_q;
  assign hit  = rise | (seen & ~start);

  always_comb begin
    last = 1'b0;
    if (start)
      last = (WIN_CYC == 1);
    else if (open)
      last = (wcnt == CNT_W'(WIN_CYC - 1));
  end

  assign loss_set = last & ~hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_q <= 1'b0;
      open <= 1'b0;
      seen <= 1'b0;
      wcnt <= '0;
      lost <= 1'b0;
    end else begin
      fb_q <= fb;
      if (start) begin
        open <= ~last;
        wcnt <= CNT_W'(1);
        seen <= rise;
      end else if (open) begin
        open <= ~last;
        wcnt <= wcnt + 1'b1;
        seen <= seen | rise;
      end
      lost <= loss_set | (lost & ~clr);
    end
  end

endmodule

// File: rtl/fire_pulse_sched.sv
// Six-slot fire pulse sequencer for the optical transmit board.
// Optional feedback loss checking is built with FIRE_FB_CHECK_EN.
module fire_pulse_sched
  import fire_pkg::*;
#(
  parameter int SLOT_CYC   = SLOT_CYC_DEF,
  parameter int PULSE_CYC  = PULSE_CYC_DEF,
  parameter int FB_WIN_CYC = FB_WIN_CYC_DEF
) (
  input  logic           i_clk_50M,
  input  logic           i_rst,
  input  logic           i_en,
  input  logic [NCH-1:0] i_mask,
  input  logic [NCH-1:0] i_fb,
  input  logic           i_clr,
  output logic [NCH-1:0] o_fire,
  output logic           o_busy,
  output logic [2:0]     o_phase,
  output logic [NCH-1:0] o_lost,
  output logic           o_fault
);

  if (PULSE_CYC >= SLOT_CYC || FB_WIN_CYC >= SLOT_CYC) begin : g_bad_cfg
    $error("fire_pulse_sched: PULSE_CYC and FB_WIN_CYC must be below SLOT_CYC");
  end

  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(SLOT_CYC - PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);

  fire_state_e      state;
  fire_state_e      state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [2:0]       phase_n;
  logic [NCH-1:0]   fire_n;
  logic             halt;

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    phase_n = o_phase;
    fire_n  = '0;
    unique case (state)
      ST_IDLE: begin
        cnt_n   = '0;
        phase_n = '0;
        if (i_en && !halt)
          state_n = ST_GAP;
      end
      ST_GAP: begin
        if (!i_en) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (cnt == GAP_LAST) begin
          state_n = ST_PULSE;
          cnt_n   = '0;
          fire_n  = phase_sel(o_phase) & i_mask;
        end
      end
      ST_PULSE: begin
        fire_n = o_fire;
        if (cnt == PULSE_LAST) begin
          fire_n = '0;
          cnt_n  = '0;
          if (!i_en || halt) begin
            state_n = ST_IDLE;
          end else begin
            state_n = ST_GAP;
            phase_n = (o_phase == 3'(NPH - 1)) ? 3'd0 : o_phase + 3'd1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_50M or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      o_phase <= '0;
      o_fire  <= '0;
      o_busy  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      o_phase <= phase_n;
      o_fire  <= fire_n;
      o_busy  <= (state_n != ST_IDLE);
    end
  end

`ifdef FIRE_FB_CHECK_EN
  logic [NCH-1:0] start_d;
  logic [NCH-1:0] start_q;
  logic [NCH-1:0] loss_set;

  // Window opens in the first cycle the pulse is on the output.
  assign start_d = (state == ST_GAP && state_n == ST_PULSE) ? fire_n : '0;
  assign halt    = o_fault | (|loss_set);

  always_ff @(posedge i_clk_50M or posedge i_rst) begin
    if (i_rst) begin
      start_q <= '0;
      o_fault <= 1'b0;
    end else begin
      start_q <= start_d;
      o_fault <= (|loss_set) | (o_fault & ~i_clr);
    end
  end

  for (genvar ch = 0; ch < NCH; ch++) begin : g_fb
    fire_fb_window #(
      .WIN_CYC (FB_WIN_CYC)
    ) u_win (
      .clk      (i_clk_50M),
      .rst      (i_rst),
      .start    (start_q[ch]),
      .fb       (i_fb[ch]),
      .clr      (i_clr),
      .lost     (o_lost[ch]),
      .loss_set (loss_set[ch])
    );
  end
`else
  logic unused_fb;

  assign halt      = 1'b0;
  assign o_lost    = '0;
  assign o_fault   = 1'b0;
  assign unused_fb = ^{i_fb, i_clr};
`endif

endmodule

// File: tb/tb_fire_pulse_sched.sv
// Directed bench for fire_pulse_sched with SLOT=20, PULSE=4, FB_WIN=6.
module tb_fire_pulse_sched;

  localparam int SLOT  = 20;
  localparam int PULSE = 4;
  localparam int WIN   = 6;
  localparam int CH_TBL [6] = '{3, 0, 5, 2, 1, 4};

  logic       i_clk_50M = 1'b0;
  logic       i_rst;
  logic       i_en;
  logic [5:0] i_mask;
  logic [5:0] i_fb;
  logic       i_clr;
  logic [5:0] o_fire;
  logic       o_busy;
  logic [2:0] o_phase;
  logic [5:0] o_lost;
  logic       o_fault;

  logic [5:0] fb_d1 = '0;
  logic [5:0] fb_d2 = '0;
  logic       fb_loop;
  logic [5:0] fb_keep;
  logic [5:0] fb_man;

  int n_vec  = 0;
  int n_miss = 0;

  always #10 i_clk_50M = ~i_clk_50M;

  always @(posedge i_clk_50M) begin
    fb_d1 <= o_fire;
    fb_d2 <= fb_d1;
  end

  always_comb i_fb = fb_loop ? (fb_d2 & fb_keep) : fb_man;

  fire_pulse_sched #(
    .SLOT_CYC   (SLOT),
    .PULSE_CYC  (PULSE),
    .FB_WIN_CYC (WIN)
  ) dut (
    .i_clk_50M (i_clk_50M),
    .i_rst     (i_rst),
    .i_en      (i_en),
    .i_mask    (i_mask),
    .i_fb      (i_fb),
    .i_clr     (i_clr),
    .o_fire    (o_fire),
    .o_busy    (o_busy),
    .o_phase   (o_phase),
    .o_lost    (o_lost),
    .o_fault   (o_fault)
  );

  // k counts cycles after the first clock edge that saw i_en high
  function automatic logic [5:0] exp_fire(input int k, input logic [5:0] m);
    int s;
    int r;
    logic [5:0] one;
    s = k / SLOT;
    r = k % SLOT;
    one = 6'd1 << CH_TBL[s % 6];
    exp_fire = (r >= SLOT - PULSE) ? (m & one) : 6'h00;
  endfunction

  function automatic logic [2:0] exp_phase(input int k);
    exp_phase = 3'((k / SLOT) % 6);
  endfunction

  task automatic do_reset;
    i_rst   = 1'b1;
    i_en    = 1'b0;
    i_mask  = 6'h3F;
    i_clr   = 1'b0;
    fb_loop = 1'b0;
    fb_keep = 6'h3F;
    fb_man  = 6'h00;
    repeat (2) @(negedge i_clk_50M);
    i_rst = 1'b0;
    @(negedge i_clk_50M);
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    #3;
    n_vec += 5;
    if (o_fire !== 6'h00) begin
      n_miss++; $display("FAIL reset_fire got %h want 00", o_fire);
    end
    if (o_busy !== 1'b0) begin
      n_miss++; $display("FAIL reset_busy got %b want 0", o_busy);
    end
    if (o_phase !== 3'd0) begin
      n_miss++; $display("FAIL reset_phase got %0d want 0", o_phase);
    end
    if (o_lost !== 6'h00) begin
      n_miss++; $display("FAIL reset_lost got %h want 00", o_lost);
    end
    if (o_fault !== 1'b0) begin
      n_miss++; $display("FAIL reset_fault got %b want 0", o_fault);
    end
    do_reset();
  endtask

  task automatic test_sequence;
    do_reset();
    i_mask = 6'h3F;
    i_en   = 1'b1;
    for (int k = 0; k < 7 * SLOT; k++) begin
      @(negedge i_clk_50M);
      n_vec += 3;
      if (o_fire !== exp_fire(k, 6'h3F)) begin
        n_miss++;
        $display("FAIL seq_fire k=%0d got %h want %h", k, o_fire, exp_fire(k, 6'h3F));
      end
      if (o_phase !== exp_phase(k)) begin
        n_miss++;
        $display("FAIL seq_phase k=%0d got %0d want %0d", k, o_phase, exp_phase(k));
      end
      if (o_busy !== 1'b1) begin
        n_miss++; $display("FAIL seq_busy k=%0d got %b want 1", k, o_busy);
      end
    end
  endtask

  task automatic test_mask;
    do_reset();
    i_mask = 6'h3E;
    i_en   = 1'b1;
    for (int k = 0; k < 4 * SLOT; k++) begin
      @(negedge i_clk_50M);
      n_vec += 2;
      if (o_fire !== exp_fire(k, 6'h3E)) begin
        n_miss++;
        $display("FAIL mask_fire k=%0d got %h want %h", k, o_fire, exp_fire(k, 6'h3E));
      end
      if (o_phase !== exp_phase(k)) begin
        n_miss++;
        $display("FAIL mask_phase k=%0d got %0d want %0d", k, o_phase, exp_phase(k));
      end
    end
  endtask

  task automatic test_mask_change;
    logic [5:0] m;
    do_reset();
    i_mask = 6'h3F;
    i_en   = 1'b1;
    for (int k = 0; k < 3 * SLOT; k++) begin
      @(negedge i_clk_50M);
      m = (k / SLOT == 1) ? 6'h00 : 6'h3F;
      n_vec++;
      if (o_fire !== exp_fire(k, m)) begin
        n_miss++;
        $display("FAIL mchg_fire k=%0d got %h want %h", k, o_fire, exp_fire(k, m));
      end
      if (k == 17) i_mask = 6'h00;
      if (k == 37) i_mask = 6'h3F;
    end
  endtask

  task automatic test_en_drop_pulse;
    do_reset();
    i_mask = 6'h3F;
    i_en   = 1'b1;
    for (int k = 0; k < 22; k++) begin
      @(negedge i_clk_50M);
      n_vec += 2;
      if (o_fire !== exp_fire(k, 6'h3F)) begin
        n_miss++;
        $display("FAIL endp_fire k=%0d got %h want %h", k, o_fire, exp_fire(k, 6'h3F));
      end
      if (o_busy !== (k < 20)) begin
        n_miss++;
        $display("FAIL endp_busy k=%0d got %b want %b", k, o_busy, k < 20);
      end
      if (k == 17) i_en = 1'b0;
    end
  endtask

  task automatic test_en_drop_gap;
    do_reset();
    i_mask = 6'h3F;
    i_en   = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge i_clk_50M);
      n_vec += 2;
      if (o_busy !== (k < 6)) begin
        n_miss++;
        $display("FAIL engap_busy k=%0d got %b want %b", k, o_busy, k < 6);
      end
      if (o_fire !== 6'h00) begin
        n_miss++; $display("FAIL engap_fire k=%0d got %h want 00", k, o_fire);
      end
      if (k == 5) i_en = 1'b0;
    end
  endtask

  task automatic test_reset_mid_pulse;
    do_reset();
    i_mask = 6'h3F;
    i_en   = 1'b1;
    repeat (58) @(negedge i_clk_50M);
    n_vec += 2;
    if (o_fire !== 6'h20) begin
      n_miss++; $display("FAIL rstp_pre_fire got %h want 20", o_fire);
    end
    if (o_phase !== 3'd2) begin
      n_miss++; $display("FAIL rstp_pre_phase got %0d want 2", o_phase);
    end
    #2 i_rst = 1'b1;
    #1;
    n_vec += 5;
    if (o_fire !== 6'h00) begin
      n_miss++; $display("FAIL rstp_fire got %h want 00", o_fire);
    end
    if (o_busy !== 1'b0) begin
      n_miss++; $display("FAIL rstp_busy got %b want 0", o_busy);
    end
    if (o_phase !== 3'd0) begin
      n_miss++; $display("FAIL rstp_phase got %0d want 0", o_phase);
    end
    if (o_lost !== 6'h00) begin
      n_miss++; $display("FAIL rstp_lost got %h want 00", o_lost);
    end
    if (o_fault !== 1'b0) begin
      n_miss++; $display("FAIL rstp_fault got %b want 0", o_fault);
    end
    do_reset();
  endtask

`ifndef FIRE_FB_CHECK_EN
  task automatic test_fb_ignored;
    do_reset();
    i_mask = 6'h3F;
    i_en   = 1'b1;
    for (int k = 0; k < 3 * SLOT; k++) begin
      @(negedge i_clk_50M);
      i_clr = (k == 30);
      n_vec += 3;
      if (o_lost !== 6'h00) begin
        n_miss++; $display("FAIL nofb_lost k=%0d got %h want 00", k, o_lost);
      end
      if (o_fault !== 1'b0) begin
        n_miss++; $display("FAIL nofb_fault k=%0d got %b want 0", k, o_fault);
      end
      if (o_busy !== 1'b1) begin
        n_miss++; $display("FAIL nofb_busy k=%0d got %b want 1", k, o_busy);
      end
    end
    i_clr = 1'b0;
  endtask
`else
  task automatic test_fb_loop;
    do_reset();
    fb_loop = 1'b1;
    fb_keep = 6'h3F;
    i_mask  = 6'h3F;
    i_en    = 1'b1;
    for (int k = 0; k < 12 * SLOT; k++) begin
      @(negedge i_clk_50M);
      n_vec += 3;
      if (o_fault !== 1'b0) begin
        n_miss++; $display("FAIL loop_fault k=%0d got %b want 0", k, o_fault);
      end
      if (o_lost !== 6'h00) begin
        n_miss++; $display("FAIL loop_lost k=%0d got %h want 00", k, o_lost);
      end
      if (o_fire !== exp_fire(k, 6'h3F)) begin
        n_miss++;
        $display("FAIL loop_fire k=%0d got %h want %h", k, o_fire, exp_fire(k, 6'h3F));
      end
    end
  endtask

  task automatic test_fb_loss;
    logic [5:0] el;
    do_reset();
    fb_loop = 1'b1;
    fb_keep = 6'h3E;
    i_mask  = 6'h3F;
    i_en    = 1'b1;
    for (int k = 0; k < 66; k++) begin
      @(negedge i_clk_50M);
      el = (k >= 42) ? 6'h01 : 6'h00;
      n_vec += 4;
      if (o_lost !== el) begin
        n_miss++; $display("FAIL loss_lost k=%0d got %h want %h", k, o_lost, el);
      end
      if (o_fault !== (k >= 42)) begin
        n_miss++; $display("FAIL loss_fault k=%0d got %b want %b", k, o_fault, k >= 42);
      end
      if (o_busy !== (k < 60)) begin
        n_miss++; $display("FAIL loss_busy k=%0d got %b want %b", k, o_busy, k < 60);
      end
      if (k < 60 && o_fire !== exp_fire(k, 6'h3F)) begin
        n_miss++;
        $display("FAIL loss_fire k=%0d got %h want %h", k, o_fire, exp_fire(k, 6'h3F));
      end
    end
    i_clr = 1'b1;
    @(negedge i_clk_50M);
    i_clr = 1'b0;
    n_vec += 3;
    if (o_fault !== 1'b0) begin
      n_miss++; $display("FAIL clr_fault got %b want 0", o_fault);
    end
    if (o_lost !== 6'h00) begin
      n_miss++; $display("FAIL clr_lost got %h want 00", o_lost);
    end
    if (o_busy !== 1'b0) begin
      n_miss++; $display("FAIL clr_busy got %b want 0", o_busy);
    end
    for (int k = 0; k < SLOT; k++) begin
      @(negedge i_clk_50M);
      n_vec += 3;
      if (o_busy !== 1'b1) begin
        n_miss++; $display("FAIL rest_busy k=%0d got %b want 1", k, o_busy);
      end
      if (o_phase !== exp_phase(k)) begin
        n_miss++;
        $display("FAIL rest_phase k=%0d got %0d want %0d", k, o_phase, exp_phase(k));
      end
      if (o_fire !== exp_fire(k, 6'h3F)) begin
        n_miss++;
        $display("FAIL rest_fire k=%0d got %h want %h", k, o_fire, exp_fire(k, 6'h3F));
      end
    end
  endtask
`endif

  initial begin
    i_rst   = 1'b1;
    i_en    = 1'b0;
    i_mask  = 6'h00;
    i_clr   = 1'b0;
    fb_loop = 1'b0;
    fb_keep = 6'h3F;
    fb_man  = 6'h00;
    test_reset();
    test_sequence();
    test_mask();
    test_mask_change();
    test_en_drop_pulse();
    test_en_drop_gap();
    test_reset_mid_pulse();
`ifndef FIRE_FB_CHECK_EN
    test_fb_ignored();
`else
    test_fb_loop();
    test_fb_loss();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
